// File: rtl/arm_pose_sequencer.sv
// Arm pose sequencer: walks the claw and the two joint servos through pick,
// drop and stow moves. Joint set-points are slew-limited once per servo frame
// tick; a phase ends after a run of settled ticks or times out into ERR.
module arm_pose_sequencer #(
  parameter int unsigned CLAW_CLOSE    = 199218,
  parameter int unsigned CLAW_OPEN     = 1,
  parameter int unsigned UPPER_PICKUP  = 31248,
  parameter int unsigned UPPER_DROPOFF = 191394,
  parameter int unsigned LOWER_PICKUP  = 183582,
  parameter int unsigned LOWER_DROPOFF = 113274,
  parameter int unsigned STEP          = 4096,
  parameter int unsigned SETTLE_TICKS  = 5,
  parameter int unsigned TIMEOUT_TICKS = 250
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TICK,
  input  logic        REQ_VALID,
  input  logic [1:0]  REQ_POSE,
  output logic        REQ_READY,
  input  logic        ABORT,
  input  logic        CLAW_FLAG,
  input  logic        JOINTHIGH_FLAG,
  input  logic        JOINTLOW_FLAG,
  output logic [19:0] CLAW_DESIRED,
  output logic [19:0] JOINTHIGH_DESIRED,
  output logic [19:0] JOINTLOW_DESIRED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [2:0]  STATE
);

  localparam int unsigned SettleW  = $clog2(SETTLE_TICKS + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [19:0] ClawClose    = 20'(CLAW_CLOSE);
  localparam logic [19:0] ClawOpen     = 20'(CLAW_OPEN);
  localparam logic [19:0] UpperPickup  = 20'(UPPER_PICKUP);
  localparam logic [19:0] UpperDropoff = 20'(UPPER_DROPOFF);
  localparam logic [19:0] LowerPickup  = 20'(LOWER_PICKUP);
  localparam logic [19:0] LowerDropoff = 20'(LOWER_DROPOFF);
  localparam logic [19:0] StepVal      = 20'(STEP);

  localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SETTLE_TICKS - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StOpen    = 3'd1,
    StLower   = 3'd2,
    StGrip    = 3'd3,
    StLift    = 3'd4,
    StRelease = 3'd5,
    StStow    = 3'd6,
    StErr     = 3'd7
  } state_e;

  state_e                state_q;
  logic [19:0]           claw_q;
  logic [19:0]           high_q;
  logic [19:0]           low_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [SettleW-1:0]    settle_q;
  logic [TimeoutW-1:0]   timeout_q;

  logic [19:0] tgt_high;
  logic [19:0] tgt_low;
  logic [19:0] ramp_high;
  logic [19:0] ramp_low;
  logic        settled;
  state_e      next_phase;
  logic [19:0] next_claw;
  state_e      start_phase;
  logic        start_valid;

  // Move cur toward tgt by at most StepVal; the distance is compared before
  // stepping so the result can never overshoot or wrap.
  function automatic logic [19:0] ramp(input logic [19:0] cur, input logic [19:0] tgt);
    logic [19:0] r;
    if (tgt >= cur) begin
      r = ((tgt - cur) <= StepVal) ? tgt : (cur + StepVal);
    end else begin
      r = ((cur - tgt) <= StepVal) ? tgt : (cur - StepVal);
    end
    return r;
  endfunction

  // Joint targets for the current phase; OPEN and RELEASE hold the joints.
  always_comb begin
    tgt_high = high_q;
    tgt_low  = low_q;
    case (state_q)
      StLower, StGrip: begin
        tgt_high = UpperPickup;
        tgt_low  = LowerPickup;
      end
      StLift, StStow: begin
        tgt_high = UpperDropoff;
        tgt_low  = LowerDropoff;
      end
      default: begin
        tgt_high = high_q;
        tgt_low  = low_q;
      end
    endcase
  end

  // Ramped joint values and the settled condition for this tick.
  always_comb begin
    ramp_high = ramp(high_q, tgt_high);
    ramp_low  = ramp(low_q, tgt_low);
    settled   = (high_q == tgt_high) && (low_q == tgt_low) &&
                CLAW_FLAG && JOINTHIGH_FLAG && JOINTLOW_FLAG;
  end

  // Phase successor and the claw target loaded on entering it.
  always_comb begin
    next_phase = StIdle;
    next_claw  = claw_q;
    case (state_q)
      StOpen: begin
        next_phase = StLower;
        next_claw  = ClawOpen;
      end
      StLower: begin
        next_phase = StGrip;
        next_claw  = ClawClose;
      end
      StGrip: begin
        next_phase = StLift;
        next_claw  = ClawClose;
      end
      default: begin
        next_phase = StIdle;
        next_claw  = claw_q;
      end
    endcase
  end

  // First phase of a requested pose; the reserved pose has none.
  always_comb begin
    start_phase = StIdle;
    start_valid = 1'b0;
    unique case (REQ_POSE)
      2'd0: begin
        start_phase = StStow;
        start_valid = 1'b1;
      end
      2'd1: begin
        start_phase = StOpen;
        start_valid = 1'b1;
      end
      2'd2: begin
        start_phase = StRelease;
        start_valid = 1'b1;
      end
      2'd3: begin
        start_phase = StIdle;
        start_valid = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and registered set-points.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      claw_q    <= ClawOpen;
      high_q    <= UpperDropoff;
      low_q     <= LowerDropoff;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      settle_q  <= '0;
      timeout_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (ABORT) begin
        // Set-points are left untouched so the arm stops where it is.
        state_q   <= StIdle;
        busy_q    <= 1'b0;
        error_q   <= 1'b0;
        settle_q  <= '0;
        timeout_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (REQ_VALID) begin
              settle_q  <= '0;
              timeout_q <= '0;
              if (start_valid) begin
                state_q <= start_phase;
                busy_q  <= 1'b1;
                claw_q  <= ClawOpen;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          StErr: begin
            // Frozen until ABORT or reset.
          end
          default: begin
            if (TICK) begin
              if (settled && (settle_q == SettleLast)) begin
                state_q   <= next_phase;
                claw_q    <= next_claw;
                settle_q  <= '0;
                timeout_q <= '0;
                if (next_phase == StIdle) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end
              end else if (timeout_q == TimeoutLast) begin
                state_q <= StErr;
                error_q <= 1'b1;
              end else begin
                settle_q  <= settled ? (settle_q + 1'b1) : '0;
                timeout_q <= timeout_q + 1'b1;
                high_q    <= ramp_high;
                low_q     <= ramp_low;
              end
            end
          end
        endcase
      end
    end
  end

  assign REQ_READY         = (state_q == StIdle) & ~ABORT;
  assign CLAW_DESIRED      = claw_q;
  assign JOINTHIGH_DESIRED = high_q;
  assign JOINTLOW_DESIRED  = low_q;
  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERROR             = error_q;
  assign STATE             = state_q;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed bench for arm_pose_sequencer: a checkpoint table for a full PICK
// plus hand-written sequences for drop, settle glitch, timeout, abort,
// stow, reserved pose and asynchronous reset.
module tb_arm_pose_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_pose = 2'd0;
  logic        req_ready;
  logic        abort = 1'b0;
  logic        claw_flag = 1'b1;
  logic        high_flag = 1'b1;
  logic        low_flag = 1'b1;
  logic [19:0] claw_des;
  logic [19:0] high_des;
  logic [19:0] low_des;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  arm_pose_sequencer dut (
    .CLK               (clk),
    .RST_N             (rst_n),
    .TICK              (tick),
    .REQ_VALID         (req_valid),
    .REQ_POSE          (req_pose),
    .REQ_READY         (req_ready),
    .ABORT             (abort),
    .CLAW_FLAG         (claw_flag),
    .JOINTHIGH_FLAG    (high_flag),
    .JOINTLOW_FLAG     (low_flag),
    .CLAW_DESIRED      (claw_des),
    .JOINTHIGH_DESIRED (high_des),
    .JOINTLOW_DESIRED  (low_des),
    .BUSY              (busy),
    .DONE              (done),
    .ERROR             (error),
    .STATE             (state)
  );

  always #5 clk = ~clk;

  // Count DONE cycles away from the active edge.
  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    int unsigned ticks;
    logic [2:0]  st;
    logic [19:0] claw;
    logic [19:0] high;
    logic [19:0] low;
    logic        busy;
  } vec_t;

  vec_t pick_tab[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      repeat (18) @(posedge clk);
    end
  endtask

  task automatic request(input logic [1:0] p);
    @(posedge clk); #1 req_valid = 1'b1; req_pose = p;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic [2:0] st, input logic [19:0] c,
                            input logic [19:0] h, input logic [19:0] l, input logic b);
    @(negedge clk);
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".claw"}, 32'(claw_des), 32'(c));
    check({name, ".high"}, 32'(high_des), 32'(h));
    check({name, ".low"}, 32'(low_des), 32'(l));
    check({name, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    //              ticks st claw    high    low     busy
    pick_tab[0]  = '{0,  1, 1,      191394, 113274, 1};
    pick_tab[1]  = '{4,  1, 1,      191394, 113274, 1};
    pick_tab[2]  = '{1,  2, 1,      191394, 113274, 1};
    pick_tab[3]  = '{1,  2, 1,      187298, 117370, 1};
    pick_tab[4]  = '{1,  2, 1,      183202, 121466, 1};
    pick_tab[5]  = '{16, 2, 1,      117666, 183582, 1};
    pick_tab[6]  = '{21, 2, 1,      31650,  183582, 1};
    pick_tab[7]  = '{1,  2, 1,      31248,  183582, 1};
    pick_tab[8]  = '{4,  2, 1,      31248,  183582, 1};
    pick_tab[9]  = '{1,  3, 199218, 31248,  183582, 1};
    pick_tab[10] = '{4,  3, 199218, 31248,  183582, 1};
    pick_tab[11] = '{1,  4, 199218, 31248,  183582, 1};
    pick_tab[12] = '{1,  4, 199218, 35344,  179486, 1};
    pick_tab[13] = '{39, 4, 199218, 191394, 113274, 1};
    pick_tab[14] = '{4,  4, 199218, 191394, 113274, 1};
    pick_tab[15] = '{1,  0, 199218, 191394, 113274, 0};

    // Reset state
    repeat (3) @(posedge clk);
    check_outs("reset", 3'd0, 20'd1, 20'd191394, 20'd113274, 1'b0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.error", 32'(error), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle.ready", 32'(req_ready), 32'd1);

    // Full PICK, all flags high
    request(2'd1);
    for (int i = 0; i < 16; i++) begin
      do_ticks(int'(pick_tab[i].ticks));
      check_outs($sformatf("pick[%0d]", i), pick_tab[i].st, pick_tab[i].claw,
                 pick_tab[i].high, pick_tab[i].low, pick_tab[i].busy);
      if (i == 5) check("pick.busy_ready", 32'(req_ready), 32'd0);
    end
    check("pick.done_cnt", 32'(done_cnt), 32'd1);

    // DROP after PICK: claw opens on entry, joints unchanged
    request(2'd2);
    check_outs("drop.entry", 3'd5, 20'd1, 20'd191394, 20'd113274, 1'b1);
    do_ticks(4);
    check_outs("drop.t4", 3'd5, 20'd1, 20'd191394, 20'd113274, 1'b1);
    do_ticks(1);
    check_outs("drop.end", 3'd0, 20'd1, 20'd191394, 20'd113274, 1'b0);
    check("drop.done_cnt", 32'(done_cnt), 32'd2);

    // Settle glitch during LOWER: 3 good ticks, 2 bad, then 5 good needed
    request(2'd1);
    do_ticks(5);
    do_ticks(40);
    check_outs("glitch.ramped", 3'd2, 20'd1, 20'd31248, 20'd183582, 1'b1);
    do_ticks(3);
    #1 low_flag = 1'b0;
    do_ticks(2);
    #1 low_flag = 1'b1;
    do_ticks(4);
    check_outs("glitch.t4", 3'd2, 20'd1, 20'd31248, 20'd183582, 1'b1);
    do_ticks(1);
    check_outs("glitch.grip", 3'd3, 20'd199218, 20'd31248, 20'd183582, 1'b1);
    pulse_abort();
    check_outs("glitch.abort", 3'd0, 20'd199218, 20'd31248, 20'd183582, 1'b0);
    check("glitch.done_cnt", 32'(done_cnt), 32'd2);

    // Timeout with claw flag stuck low
    #1 claw_flag = 1'b0;
    request(2'd1);
    do_ticks(249);
    check_outs("tmo.t249", 3'd1, 20'd1, 20'd31248, 20'd183582, 1'b1);
    check("tmo.err_early", 32'(error), 32'd0);
    do_ticks(1);
    check_outs("tmo.err", 3'd7, 20'd1, 20'd31248, 20'd183582, 1'b1);
    check("tmo.error", 32'(error), 32'd1);
    check("tmo.ready", 32'(req_ready), 32'd0);
    do_ticks(3);
    check_outs("tmo.frozen", 3'd7, 20'd1, 20'd31248, 20'd183582, 1'b1);
    #1 claw_flag = 1'b1;
    pulse_abort();
    check_outs("tmo.abort", 3'd0, 20'd1, 20'd31248, 20'd183582, 1'b0);
    check("tmo.error_clr", 32'(error), 32'd0);
    check("tmo.ready_back", 32'(req_ready), 32'd1);
    check("tmo.done_cnt", 32'(done_cnt), 32'd2);

    // ABORT together with REQ_VALID in IDLE
    @(posedge clk); #1 abort = 1'b1; req_valid = 1'b1; req_pose = 2'd1;
    @(negedge clk);
    check("abtreq.ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 abort = 1'b0; req_valid = 1'b0;
    check_outs("abtreq.idle", 3'd0, 20'd1, 20'd31248, 20'd183582, 1'b0);

    // STOW from pickup joints
    request(2'd0);
    do_ticks(40);
    check_outs("stow.ramped", 3'd6, 20'd1, 20'd191394, 20'd113274, 1'b1);
    do_ticks(4);
    check_outs("stow.t44", 3'd6, 20'd1, 20'd191394, 20'd113274, 1'b1);
    do_ticks(1);
    check_outs("stow.end", 3'd0, 20'd1, 20'd191394, 20'd113274, 1'b0);
    check("stow.done_cnt", 32'(done_cnt), 32'd3);

    // ABORT mid-ramp freezes intermediate set-points
    request(2'd1);
    do_ticks(8);
    check_outs("mid.ramp", 3'd2, 20'd1, 20'd179106, 20'd125562, 1'b1);
    pulse_abort();
    check_outs("mid.abort", 3'd0, 20'd1, 20'd179106, 20'd125562, 1'b0);
    do_ticks(3);
    check_outs("mid.hold", 3'd0, 20'd1, 20'd179106, 20'd125562, 1'b0);
    check("mid.done_cnt", 32'(done_cnt), 32'd3);

    // Reserved pose: DONE one cycle after acceptance, nothing moves
    request(2'd3);
    @(negedge clk);
    check("rsv.done", 32'(done), 32'd1);
    check("rsv.busy", 32'(busy), 32'd0);
    check_outs("rsv.after", 3'd0, 20'd1, 20'd179106, 20'd125562, 1'b0);
    check("rsv.done_low", 32'(done), 32'd0);
    check("rsv.done_cnt", 32'(done_cnt), 32'd4);

    // Asynchronous reset mid-move
    request(2'd1);
    do_ticks(7);
    @(negedge clk);
    check("arst.pre_state", 32'(state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst.state", 32'(state), 32'd0);
    check("arst.claw", 32'(claw_des), 32'd1);
    check("arst.high", 32'(high_des), 32'd191394);
    check("arst.low", 32'(low_des), 32'd113274);
    check("arst.busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_pose_sequencer.md
Name: arm_pose_sequencer

Overview:
- Sequences the three arm servos (claw, upper joint, lower joint) through multi-phase pick, drop and stow moves on request from the navigation controller.
- Slew-limits joint set-points once per servo PWM frame, so the arm no longer jumps straight to a new position.
- Its outputs drive the DESIRED inputs of the three Servo instances. It consumes their FLAG outputs plus the frame tick derived from the shared 2,000,001-count servo counter.

Parameters:
- CLAW_CLOSE, 199218, claw closed set-point (100 MHz counts)
- CLAW_OPEN, 1, claw open set-point
- UPPER_PICKUP, 31248, upper joint pickup set-point
- UPPER_DROPOFF, 191394, upper joint carry/drop set-point
- LOWER_PICKUP, 183582, lower joint pickup set-point
- LOWER_DROPOFF, 113274, lower joint carry/drop set-point
- STEP, 4096, maximum joint set-point change per frame tick
- SETTLE_TICKS, 5, consecutive settled ticks required to end a phase
- TIMEOUT_TICKS, 250, ticks allowed per phase before error (about 5 s)

Ports:
- CLK  in  1  100 MHz system clock
- RST_N  in  1  reset, asynchronous, active-low
- TICK  in  1  one-cycle pulse per servo frame (COUNT wrap)
- REQ_VALID  in  1  move request valid
- REQ_POSE  in  2  0=STOW, 1=PICK, 2=DROP, 3=reserved
- REQ_READY  out  1  high when a request can be accepted
- ABORT  in  1  synchronous abort
- CLAW_FLAG  in  1  claw servo at set-point
- JOINTHIGH_FLAG  in  1  upper servo at set-point
- JOINTLOW_FLAG  in  1  lower servo at set-point
- CLAW_DESIRED  out  20  claw set-point
- JOINTHIGH_DESIRED  out  20  upper joint set-point
- JOINTLOW_DESIRED  out  20  lower joint set-point
- BUSY  out  1  move in progress
- DONE  out  1  one-cycle pulse on move completion
- ERROR  out  1  sticky phase-timeout flag
- STATE  out  3  current state, for debug LEDs

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values:
  - CLAW_DESIRED=CLAW_OPEN, JOINTHIGH_DESIRED=UPPER_DROPOFF, JOINTLOW_DESIRED=LOWER_DROPOFF.
  - BUSY=0, DONE=0, ERROR=0, state=IDLE, all counters 0.
- States: IDLE(0), OPEN(1), LOWER(2), GRIP(3), LIFT(4), RELEASE(5), STOW(6), ERR(7). STATE reflects this encoding.
- Handshake:
  - REQ_READY = (state==IDLE) & ~ABORT.
  - A request is accepted on REQ_VALID&REQ_READY. The first phase is entered on the next edge, with BUSY high from that edge.
- Phase sequences:
  - PICK = OPEN -> LOWER -> GRIP -> LIFT.
  - DROP = RELEASE.
  - STOW = STOW.
  - Reserved pose: accepted; DONE pulses on the next cycle and nothing moves.
- Phase targets (claw, upper, lower):
  - OPEN: CLAW_OPEN, held current, held current
  - LOWER: CLAW_OPEN, UPPER_PICKUP, LOWER_PICKUP
  - GRIP: CLAW_CLOSE, UPPER_PICKUP, LOWER_PICKUP
  - LIFT: CLAW_CLOSE, UPPER_DROPOFF, LOWER_DROPOFF
  - RELEASE: CLAW_OPEN, held current, held current
  - STOW: CLAW_OPEN, UPPER_DROPOFF, LOWER_DROPOFF
- Claw set-point loads its target directly on phase entry.
- Joint ramp, on each TICK only:
  - If |target-desired| <= STEP: desired=target; else desired moves toward target by STEP.
  - Arithmetic is unsigned 20-bit and must never overshoot or wrap.
- Settle counter, on each TICK in an active phase:
  - Increments if both joint set-points equal their targets and all three FLAGs are high; otherwise clears to 0.
  - When it reaches SETTLE_TICKS, the next phase is entered on that edge and the settle and timeout counters clear.
- Completion: after the last phase settles, state=IDLE, DONE=1 for exactly one cycle, BUSY=0 on the same edge.
- Timeout counter: increments on each TICK in an active phase. On reaching TIMEOUT_TICKS: state=ERR, ERROR=1, BUSY stays 1, all set-points frozen, no DONE.
- ERR is left only by ABORT or reset.
- ABORT, in any state, takes effect on the next edge:
  - state=IDLE, BUSY=0, ERROR=0, counters clear, no DONE.
  - Set-points freeze at their current values (no jump).
- ABORT and REQ_VALID together in IDLE: ABORT wins and the request is not accepted.
- TICK is ignored in IDLE and ERR; set-points stay constant there.
- REQ_VALID while BUSY: not accepted (REQ_READY=0) and must be held by the requester.
- Reset mid-move: outputs go immediately (asynchronously) to their reset values.

Test Plan:
- Reset then PICK, all FLAGs tied high, TICK every 20 cycles:
  - Phases 1->2->3->4 in order. JOINTHIGH_DESIRED steps 191394->187298->... reaching 31248 after 40 ticks.
  - DONE pulses once. Final values: CLAW=199218, HIGH=191394, LOW=113274.
- DROP after PICK: CLAW_DESIRED goes 199218->1 on phase entry; DONE after 5 settled ticks; joints unchanged.
- During LOWER, drop JOINTLOW_FLAG for 2 ticks at settle count 3: settle counter clears to 0; phase ends exactly 5 good ticks later.
- PICK with CLAW_FLAG stuck low: ERR after 250 ticks, ERROR=1, set-points frozen. Then ABORT -> IDLE, ERROR=0, REQ_READY=1, no DONE.
- ABORT asserted with REQ_VALID in IDLE: no acceptance. Same in mid-ramp: set-points hold the intermediate value (e.g. 179106).
- REQ_POSE=3: DONE one cycle after acceptance, BUSY never high, set-points unchanged.
